// File: rtl/ads_spi_frame_master.sv
// ads_spi_frame_master: SPI mode-1 master running back-to-back 16-bit ADS frames with a frame counter.
// Optional command transmit on ads_mosi is enabled by defining ADS_CMD_TX_EN.
`default_nettype none

module ads_spi_frame_master #(
    parameter int CLK_DIV   = 4,
    parameter int CS_IDLE   = 8,
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WORD_BITS-1:0] cmd_word,
    input  logic                 ads_miso,
    output logic                 ads_sclk,
    output logic                 ads_cs,
    output logic                 ads_mosi,
    output logic [WORD_BITS-1:0] receive_data,
    output logic [15:0]          pkg_num,
    output logic                 data_valid,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_IDLE - 1);
    localparam logic [3:0] LAST_BIT = 4'(WORD_BITS - 1);

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [7:0]           div_cnt;
    logic [3:0]           bit_cnt;
    logic                 sclk_q;
    logic                 cs_q;
    logic                 dv_q;
    logic [WORD_BITS-1:0] rx_sr;
    logic [WORD_BITS-1:0] rx_word;
    logic [15:0]          pkg_cnt;
    logic                 div_last;
    logic                 gap_last;
    logic                 setup_entry;

    assign div_last    = (div_cnt == DIV_LAST);
    assign gap_last    = (div_cnt == GAP_LAST);
    assign setup_entry = (next_state == S_SETUP) && (state != S_SETUP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; en only matters at frame boundaries so frames are never truncated
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (en) next_state = S_SETUP;
            S_SETUP: if (div_last) next_state = S_SHIFT;
            S_SHIFT: if (div_last && !sclk_q && (bit_cnt == 4'd0)) next_state = S_HOLD;
            S_HOLD:  if (div_last) next_state = S_GAP;
            S_GAP:   if (gap_last) next_state = en ? S_SETUP : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy         = (state != S_IDLE);
        ads_cs       = cs_q;
        ads_sclk     = sclk_q;
        receive_data = rx_word;
        pkg_num      = pkg_cnt;
        data_valid   = dv_q;
    end

    // Datapath: cs is registered from next_state so it can never glitch on state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            dv_q    <= 1'b0;
            rx_sr   <= '0;
            rx_word <= '0;
            pkg_cnt <= 16'd0;
        end else begin
            dv_q <= 1'b0;
            cs_q <= (next_state == S_IDLE) || (next_state == S_GAP);

            if ((state == S_IDLE) || (state != next_state) || ((state == S_SHIFT) && div_last)) begin
                div_cnt <= 8'd0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (en) pkg_cnt <= 16'd0;
                end
                S_SETUP: begin
                    if (div_last) begin
                        sclk_q  <= 1'b1;
                        bit_cnt <= LAST_BIT;
                    end
                end
                S_SHIFT: begin
                    if (div_last) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            rx_sr  <= {rx_sr[WORD_BITS-2:0], ads_miso};
                        end else if (bit_cnt != 4'd0) begin
                            sclk_q  <= 1'b1;
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (div_last) begin
                        rx_word <= rx_sr;
                        pkg_cnt <= (pkg_cnt == 16'hFFFF) ? pkg_cnt : pkg_cnt + 16'd1;
                        dv_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADS_CMD_TX_EN
    logic [WORD_BITS-1:0] tx_sr;
    logic                 mosi_q;

    // MSB goes out at SETUP entry; later bits follow every rising edge after the first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr  <= '0;
            mosi_q <= 1'b0;
        end else if (setup_entry) begin
            tx_sr  <= cmd_word;
            mosi_q <= cmd_word[WORD_BITS-1];
        end else if ((state == S_SHIFT) && div_last && !sclk_q) begin
            if (bit_cnt != 4'd0) begin
                mosi_q <= tx_sr[WORD_BITS-2];
                tx_sr  <= {tx_sr[WORD_BITS-2:0], 1'b0};
            end else begin
                mosi_q <= 1'b0;
            end
        end
    end

    assign ads_mosi = mosi_q;
`else
    logic unused_cmd;
    assign unused_cmd = ^{cmd_word, setup_entry};
    assign ads_mosi   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/ads_spi_frame_master.md
Name: ads_spi_frame_master

Overview:
- SPI master for the ADS converter. Runs back-to-back 16-bit frames: ads_cs low, 16 sclk periods, ads_cs high for a fixed gap.
- Presents each captured word on receive_data and a running frame count on pkg_num.
- Sits directly upstream of the ADS channel demux. That stage reacts to the ads_cs rising edge and uses pkg_num >= 6 to start channel rotation.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period; legal range 2..255.
- CS_IDLE, 8: clk cycles ads_cs is held high between frames; legal range 4..255.
- WORD_BITS, 16: bits per frame; fixed at 16 for this converter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level; frames run while high
- cmd_word  in  16  word shifted out on ads_mosi (see Optional Feature)
- ads_miso  in  1  serial data from converter
- ads_sclk  out  1  serial clock; idles low
- ads_cs  out  1  chip select, active low
- ads_mosi  out  1  serial data to converter
- receive_data  out  16  last completed word, MSB first on the wire
- pkg_num  out  16  completed frames since the burst started; saturates at 16'hFFFF
- data_valid  out  1  one-cycle pulse when receive_data and pkg_num update
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async, rst_n low): state IDLE, ads_cs=1, ads_sclk=0, ads_mosi=0, receive_data=0, pkg_num=0, data_valid=0, busy=0. All divider and bit counters are cleared.
- Reset asserted mid-frame aborts the frame immediately: ads_cs goes high asynchronously and pkg_num is not incremented.
- SPI mode 1 (CPOL=0, CPHA=1):
  - ads_mosi changes on the sclk rising edge.
  - ads_miso is sampled in the clk cycle that produces the sclk falling edge.
- State IDLE:
  - If en=1, clear pkg_num to 0, drive ads_cs=0 and go to SETUP.
- State SETUP: CLK_DIV cycles with cs low and sclk low, then go to SHIFT.
- State SHIFT:
  - 16 sclk periods; each period is CLK_DIV cycles high then CLK_DIV cycles low.
  - The bit counter counts 15 down to 0.
  - The shift register shifts left and takes in ads_miso at each falling edge.
  - After the 16th falling edge, go to HOLD.
- State HOLD: CLK_DIV cycles. On the last cycle:
  - receive_data <= shift register.
  - pkg_num <= pkg_num+1, saturating at 16'hFFFF.
  - data_valid=1 for that cycle.
  - ads_cs <= 1 on the same edge.
- receive_data must be stable before ads_cs rises and stay stable until the next HOLD completes. The downstream stage samples it 2–3 clk cycles after its synchronised cs edge.
- State GAP: CS_IDLE cycles with ads_cs=1.
  - At the end, if en=1, go to SETUP (cs low, no pkg_num clear).
  - Otherwise go to IDLE.
- en deasserted mid-frame: the current frame completes normally, including the pkg_num update, then the block returns to IDLE. A frame is never truncated by en.
- en toggling low then high while in GAP: has no effect on pkg_num. Only IDLE→SETUP clears it.
- Frame period: CLK_DIV*34 + CS_IDLE clk cycles, which is 144 cycles at defaults.
- No sclk edges ever occur while ads_cs=1.

Optional Feature:
- Macro ADS_CMD_TX_EN.
- Defined:
  - cmd_word is latched at SETUP entry.
  - Bit 15 is driven on ads_mosi at SETUP entry.
  - Each following bit is driven on each sclk rising edge after the first.
  - ads_mosi returns to 0 in HOLD.
- Not defined: ads_mosi is tied to 0 and cmd_word is unused.

Test Plan:
- Reset then en=1 with a converter model returning 16'hA5C3 → data_valid pulses once and receive_data=16'hA5C3, pkg_num=1, with ads_cs rising on that same edge. Next data_valid follows 144 cycles later.
- Hold en=1 for 8 frames with words 16'h0001..16'h0008 → pkg_num steps 1..8, and each receive_data matches its frame's word.
- Drop en during the 5th bit of frame 3 → frame 3 completes (pkg_num=3), then IDLE with ads_cs=1 and no further sclk. Re-raise en → pkg_num returns to 0 and then 1 after the next frame.
- Assert rst_n=0 mid-SHIFT → ads_cs=1, sclk=0 and all outputs at reset values within the same cycle. After release with en=1, the first frame gives pkg_num=1.
- Force pkg_num near 16'hFFFE and run 3 frames → values 16'hFFFF, 16'hFFFF, 16'hFFFF (saturate, no wrap).
- With ADS_CMD_TX_EN and cmd_word=16'h8F01 → the bench samples ads_mosi on sclk falling edges and reads 16'h8F01. Without the macro, ads_mosi stays 0 throughout.
